// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared widths, edge columns, FSM state codes and helpers for the pong match sequencer
package pong_pkg;

  // Datapath widths shared by the match controller and its neighbours
  localparam int SCORE_W = 4;
  localparam int POS_W   = 4;
  localparam int SPEED_W = 5;

  // Playfield edge columns
  localparam logic [POS_W-1:0] EDGE_L = 4'd0;
  localparam logic [POS_W-1:0] EDGE_R = 4'd15;

  // Ball column the previous-position register restarts from (centre)
  localparam logic [POS_W-1:0] CENTRE_X = 4'd8;

  // Match FSM encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_SERVE    = 3'd1;
  localparam state_t ST_PLAY     = 3'd2;
  localparam state_t ST_POINT    = 3'd3;
  localparam state_t ST_GAMEOVER = 3'd4;

  // Score increment that holds at the top of the counter instead of wrapping
  function automatic logic [SCORE_W-1:0] score_sat_inc(input logic [SCORE_W-1:0] s);
    logic [SCORE_W-1:0] r;
    r = (s == {SCORE_W{1'b1}}) ? s : s + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/pong_hold_timer.sv
// rtl/pong_hold_timer.sv - cycle hold timer with clear, count enable and one-cycle done pulse
module pong_hold_timer #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] ticks,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // done fires on the last cycle of a ticks-long hold; the owner changes state on it
  assign done = en && (count_q == ticks - 1'b1);

  // Next count: clear wins, otherwise advance while enabled and restart after done
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = done ? '0 : count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - pong match sequencer: serve, edge scoring, speed ramp, game over (option: PONG_SPEED_RAMP_EN)
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int PADDLE_H    = 3,
  parameter int BASE_SPEED  = 4,
  parameter int MAX_SPEED   = 12,
  parameter int SERVE_TICKS = 1000,
  parameter int POINT_TICKS = 2000,
  parameter int WIN_SCORE   = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [POS_W-1:0]   ball_x,
  input  logic [POS_W-1:0]   ball_y,
  input  logic [POS_W-1:0]   paddle_l_y,
  input  logic [POS_W-1:0]   paddle_r_y,
  output logic               ball_reset,
  output logic [SPEED_W-1:0] ball_speed,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over
);

  // Hold timer wide enough for the longer of the two pauses
  localparam int MAX_TICKS = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
  localparam int TIMER_W   = $clog2(MAX_TICKS + 1);

`ifdef PONG_SPEED_RAMP_EN
  localparam logic RAMP_EN = 1'b1;
`else
  localparam logic RAMP_EN = 1'b0;
`endif

  localparam logic [SPEED_W-1:0] BASE_MAG = SPEED_W'(BASE_SPEED);
  localparam logic [SPEED_W-1:0] MAX_MAG  = SPEED_W'(MAX_SPEED);
  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);

  state_t             state_q,      state_d;
  logic               ball_reset_q, ball_reset_d;
  logic [SPEED_W-1:0] ball_speed_q, ball_speed_d;
  logic [SCORE_W-1:0] score_l_q,    score_l_d;
  logic [SCORE_W-1:0] score_r_q,    score_r_d;
  logic               game_over_q,  game_over_d;
  logic               serve_dir_q,  serve_dir_d;
  logic [POS_W-1:0]   prev_x_q,     prev_x_d;

  logic               left_evt;
  logic               right_evt;
  logic               hit_l;
  logic               hit_r;
  logic [SPEED_W-1:0] speed_mag;
  logic [SPEED_W-1:0] ramp_mag;
  logic [SPEED_W-1:0] ramp_speed;
  logic [SPEED_W-1:0] hit_speed;
  logic [SPEED_W-1:0] play_speed;
  logic               timer_en;
  logic               timer_clear;
  logic               timer_done;
  logic [TIMER_W-1:0] timer_ticks;

  // Edge arrivals: the ball must move onto an edge column, so sitting there never re-fires
  assign left_evt  = (prev_x_q != EDGE_L) && (ball_x == EDGE_L);
  assign right_evt = (prev_x_q != EDGE_R) && (ball_x == EDGE_R) && !left_evt;

  // Paddle spans compared one bit wider so a paddle reaching past row 15 clips instead of wrapping
  assign hit_l = ({1'b0, ball_y} >= {1'b0, paddle_l_y}) &&
                 ({1'b0, ball_y} <= ({1'b0, paddle_l_y} + (POS_W+1)'(PADDLE_H - 1)));
  assign hit_r = ({1'b0, ball_y} >= {1'b0, paddle_r_y}) &&
                 ({1'b0, ball_y} <= ({1'b0, paddle_r_y} + (POS_W+1)'(PADDLE_H - 1)));

  // Speed after a paddle hit: magnitude steps up to the ceiling, sign is kept
  always_comb begin
    speed_mag  = ball_speed_q[SPEED_W-1] ? -ball_speed_q : ball_speed_q;
    ramp_mag   = (speed_mag >= MAX_MAG) ? MAX_MAG : speed_mag + 1'b1;
    ramp_speed = ball_speed_q[SPEED_W-1] ? -ramp_mag : ramp_mag;
    hit_speed  = RAMP_EN ? ramp_speed : ball_speed_q;
  end

  // The hold timer runs only in the two pause states and restarts on every state change
  assign timer_en    = (state_q == ST_SERVE) || (state_q == ST_POINT);
  assign timer_clear = (state_d != state_q);
  assign timer_ticks = (state_q == ST_SERVE) ? TIMER_W'(SERVE_TICKS) : TIMER_W'(POINT_TICKS);

  pong_hold_timer #(
    .W (TIMER_W)
  ) u_hold_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .en    (timer_en),
    .ticks (timer_ticks),
    .done  (timer_done)
  );

  // Match FSM, scoring and serve direction
  always_comb begin
    state_d     = state_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    serve_dir_d = serve_dir_q;
    play_speed  = ball_speed_q;
    prev_x_d    = ball_x;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SERVE;
          score_l_d = '0;
          score_r_d = '0;
        end
      end

      ST_SERVE: begin
        if (timer_done) begin
          state_d = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (left_evt) begin
          if (hit_l) begin
            play_speed = hit_speed;
          end else begin
            // Right player scores; the next serve heads toward the left player who lost it
            score_r_d   = score_sat_inc(score_r_q);
            serve_dir_d = 1'b1;
            state_d     = ST_POINT;
          end
        end else if (right_evt) begin
          if (hit_r) begin
            play_speed = hit_speed;
          end else begin
            score_l_d   = score_sat_inc(score_l_q);
            serve_dir_d = 1'b0;
            state_d     = ST_POINT;
          end
        end
      end

      ST_POINT: begin
        if (timer_done) begin
          state_d = ((score_l_q == WIN_VAL) || (score_r_q == WIN_VAL)) ? ST_GAMEOVER : ST_SERVE;
        end
      end

      ST_GAMEOVER: begin
        if (start) begin
          state_d     = ST_SERVE;
          score_l_d   = '0;
          score_r_d   = '0;
          serve_dir_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Ball-facing outputs follow the next state so they register together with it
  always_comb begin
    ball_reset_d = (state_d != ST_PLAY);
    game_over_d  = (state_d == ST_GAMEOVER);
    if (state_d != ST_PLAY) begin
      ball_speed_d = '0;
    end else if (state_q != ST_PLAY) begin
      ball_speed_d = serve_dir_q ? -BASE_MAG : BASE_MAG;
    end else begin
      ball_speed_d = play_speed;
    end
  end

  // State and output registers; reset drops straight back to a centred, stopped ball
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ball_reset_q <= 1'b1;
      ball_speed_q <= '0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      game_over_q  <= 1'b0;
      serve_dir_q  <= 1'b0;
      prev_x_q     <= CENTRE_X;
    end else begin
      state_q      <= state_d;
      ball_reset_q <= ball_reset_d;
      ball_speed_q <= ball_speed_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      game_over_q  <= game_over_d;
      serve_dir_q  <= serve_dir_d;
      prev_x_q     <= prev_x_d;
    end
  end

  assign ball_reset = ball_reset_q;
  assign ball_speed = ball_speed_q;
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - directed self-checking bench for pong_match_ctrl
module tb_pong_match_ctrl;

`ifdef PONG_SPEED_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] ball_x;
  logic [3:0] ball_y;
  logic [3:0] paddle_l_y;
  logic [3:0] paddle_r_y;
  logic       ball_reset;
  logic [4:0] ball_speed;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n;
  int exp_spd;

  pong_match_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .paddle_l_y (paddle_l_y),
    .paddle_r_y (paddle_r_y),
    .ball_reset (ball_reset),
    .ball_speed (ball_speed),
    .score_l    (score_l),
    .score_r    (score_r),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, $signed(obs), exp);
    end
  endtask

  task automatic chk_spd(input string tag, input int exp);
    chk(tag, 32'($signed(ball_speed)), exp);
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_release(output int cycles);
    cycles = 0;
    while (ball_reset === 1'b1 && cycles < 4000) begin
      tick(1);
      cycles++;
    end
  endtask

  task automatic wait_gameover(output int cycles);
    cycles = 0;
    while (game_over !== 1'b1 && cycles < 4000) begin
      tick(1);
      cycles++;
    end
  endtask

  task automatic edge_left(input logic [3:0] y, input logic [3:0] p);
    paddle_l_y = p;
    ball_y     = y;
    ball_x     = 4'd1;
    tick(1);
    ball_x = 4'd0;
    tick(1);
    ball_x = 4'd8;
  endtask

  task automatic edge_right(input logic [3:0] y, input logic [3:0] p);
    paddle_r_y = p;
    ball_y     = y;
    ball_x     = 4'd14;
    tick(1);
    ball_x = 4'd15;
    tick(1);
    ball_x = 4'd8;
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    ball_x     = 4'd8;
    ball_y     = 4'd0;
    paddle_l_y = 4'd0;
    paddle_r_y = 4'd0;
    tick(2);
    chk("rst_ball_reset", ball_reset, 1);
    chk_spd("rst_speed", 0);
    chk("rst_score_l", score_l, 0);
    chk("rst_score_r", score_r, 0);
    chk("rst_game_over", game_over, 0);

    reset = 1'b0;
    tick(3);
    chk("idle_hold", ball_reset, 1);

    // Serve from IDLE
    press_start();
    wait_release(n);
    chk("serve_latency", n, 1000);
    chk_spd("serve_speed", 4);
    chk("serve_score_l", score_l, 0);
    chk("serve_score_r", score_r, 0);

    // Right miss scores for the left player
    edge_right(4'd2, 4'd10);
    chk("rmiss_score_l", score_l, 1);
    chk("rmiss_score_r", score_r, 0);
    chk("rmiss_ball_reset", ball_reset, 1);
    chk_spd("rmiss_speed", 0);
    wait_release(n);
    chk("rmiss_pause", n, 3000);
    chk_spd("rmiss_serve", 4);

    // Paddle clipped at the bottom: row 15 is a hit, row 0 does not wrap into it
    edge_right(4'd15, 4'd14);
    chk_spd("clip_hit_speed", RAMP ? 5 : 4);
    chk("clip_hit_live", ball_reset, 0);
    edge_right(4'd0, 4'd14);
    chk("clip_nowrap_score_l", score_l, 2);
    wait_release(n);
    chk("clip_pause", n, 3000);
    chk_spd("clip_serve", 4);

    // Left miss: right scores, serve flips left
    edge_left(4'd0, 4'd8);
    chk("lmiss_score_r", score_r, 1);
    wait_release(n);
    chk("lmiss_pause", n, 3000);
    chk_spd("lmiss_serve", -4);

    // Hits keep the sign and ramp the magnitude; range ends inclusive
    edge_left(4'd5, 4'd4);
    chk_spd("hit_l_mid", RAMP ? -5 : -4);
    edge_right(4'd12, 4'd10);
    chk_spd("hit_r_bottom", RAMP ? -6 : -4);
    edge_left(4'd4, 4'd4);
    chk_spd("hit_l_top", RAMP ? -7 : -4);
    chk("hits_score_l", score_l, 2);
    chk("hits_score_r", score_r, 1);

    // start is ignored during play
    press_start();
    chk("play_start_ign", ball_reset, 0);
    chk_spd("play_start_spd", RAMP ? -7 : -4);

    // Asynchronous reset mid-rally
    reset = 1'b1;
    #1;
    chk("arst_ball_reset", ball_reset, 1);
    chk_spd("arst_speed", 0);
    chk("arst_score_l", score_l, 0);
    chk("arst_score_r", score_r, 0);
    chk("arst_game_over", game_over, 0);
    tick(2);
    reset = 1'b0;
    tick(5);
    chk("arst_idle", ball_reset, 1);

    // Ramp saturation over 12 hits
    press_start();
    wait_release(n);
    chk("sat_serve_latency", n, 1000);
    chk_spd("sat_serve", 4);
    for (int k = 1; k <= 12; k++) begin
      edge_left(4'd5, 4'd4);
      exp_spd = RAMP ? ((4 + k > 12) ? 12 : 4 + k) : 4;
      chk_spd("sat_hit", exp_spd);
    end

    // Run the right player up to the winning score
    for (int i = 1; i <= 8; i++) begin
      edge_left(4'd0, 4'd8);
      chk("win_score_r", score_r, i);
      wait_release(n);
      chk("win_pause", n, 3000);
    end
    chk_spd("win_serve_dir", -4);
    edge_left(4'd0, 4'd8);
    chk("final_score_r", score_r, 9);
    chk("final_ball_reset", ball_reset, 1);
    chk("final_not_over", game_over, 0);
    wait_gameover(n);
    chk("gameover_latency", n, 2000);
    chk("gameover_flag", game_over, 1);
    chk("gameover_ball_reset", ball_reset, 1);
    chk("gameover_score_l", score_l, 0);
    tick(10);
    chk("gameover_hold", game_over, 1);

    // Restart from game over
    press_start();
    chk("restart_game_over", game_over, 0);
    chk("restart_score_r", score_r, 0);
    chk("restart_ball_reset", ball_reset, 1);
    wait_release(n);
    chk("restart_latency", n, 1000);
    chk_spd("restart_serve", 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
